// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM encoding, the
// instruction length, redirect-cause encoding and the PC alignment helper.
package fetch_stage_pkg;

    localparam logic [63:0] ILEN = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        RC_NONE   = 2'd0,
        RC_BRANCH = 2'd1,
        RC_TRAP   = 2'd2
    } redir_cause_e;

    // Clear the two low bits so every fetch address is word-aligned.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a word that arrived while the DE latch
// could not accept it.
module fetch_skid_buf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        clr_i,
    input  logic [31:0] data_i,
    input  logic [63:0] npc_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [63:0] npc_o
);

    logic        valid_q;
    logic [31:0] data_q;
    logic [63:0] npc_q;

    // Capture on push; clear drops the entry, push wins if both are seen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            npc_q   <= '0;
        end else if (push_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            npc_q   <= npc_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches, feeds the DE latch, parks a
// word in the skid buffer on stall, and handles trap/branch redirects.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no request outstanding; issue next fetch when allowed
// REQ      | request to PC outstanding; streams one word per cycle
// DRAIN    | redirect seen mid-request; wait for the response, discard it
// HOLD     | word parked in skid buffer until the pipeline can take it
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_RDY,
    input  logic [31:0] IMEM_DATA,
    input  logic        BR_STALL,
    input  logic        V_MEM_STALL,
    input  logic        MEM_BR_TAKEN,
    input  logic [63:0] MEM_BR_TARGET,
    input  logic        DE_CS,
    input  logic [63:0] DE_MTVEC,
    output logic [63:0] DE_NPC,
    output logic [31:0] DE_IR,
    output logic        DE_V
);
    import fetch_stage_pkg::*;

    fetch_state_e state_q;
    logic [63:0]  pc_q;
    logic [63:0]  redir_pc_q;
    logic         req_q;
    logic         de_v_q;
    logic [31:0]  de_ir_q;
    logic [63:0]  de_npc_q;

    redir_cause_e cause;
    logic         redir;
    logic [63:0]  redir_tgt;
    logic         stall;
    logic [63:0]  pc_inc;
    logic         skid_push;
    logic         skid_clr;
    logic         skid_v;
    logic [31:0]  skid_data;
    logic [63:0]  skid_npc;

    // Redirect arbitration: trap beats resolved branch beats sequential.
    always_comb begin
        cause = RC_NONE;
        if (DE_CS) begin
            cause = RC_TRAP;
        end else if (MEM_BR_TAKEN) begin
            cause = RC_BRANCH;
        end
    end

    assign redir     = (cause != RC_NONE);
    assign redir_tgt = align_pc((cause == RC_TRAP) ? DE_MTVEC : MEM_BR_TARGET);
    assign stall     = V_MEM_STALL | BR_STALL;
    assign pc_inc    = pc_q + ILEN;
    assign skid_push = (state_q == ST_REQ) && IMEM_RDY && !redir && stall;
    assign skid_clr  = (state_q == ST_HOLD) && (redir || !stall);

    fetch_skid_buf u_skid (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .push_i  (skid_push),
        .clr_i   (skid_clr),
        .data_i  (IMEM_DATA),
        .npc_i   (pc_inc),
        .valid_o (skid_v),
        .data_o  (skid_data),
        .npc_o   (skid_npc)
    );

    // Fetch FSM, PC, redirect holding register and DE latch.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            redir_pc_q <= '0;
            req_q      <= 1'b0;
            de_v_q     <= 1'b0;
            de_ir_q    <= '0;
            de_npc_q   <= '0;
        end else begin
            // DE latch holds under downstream stall; otherwise bubble
            // unless a word is delivered and no redirect squashes it.
            if (!V_MEM_STALL) begin
                de_v_q <= 1'b0;
                if (!redir && !BR_STALL) begin
                    if (state_q == ST_REQ && IMEM_RDY) begin
                        de_v_q   <= 1'b1;
                        de_ir_q  <= IMEM_DATA;
                        de_npc_q <= pc_inc;
                    end else if (state_q == ST_HOLD) begin
                        de_v_q   <= 1'b1;
                        de_ir_q  <= skid_data;
                        de_npc_q <= skid_npc;
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (redir) begin
                        pc_q <= redir_tgt;
                    end else if (!BR_STALL && !skid_v) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (redir) begin
                        if (IMEM_RDY) begin
                            pc_q    <= redir_tgt;
                            state_q <= ST_IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            redir_pc_q <= redir_tgt;
                            state_q    <= ST_DRAIN;
                        end
                    end else if (IMEM_RDY) begin
                        if (stall) begin
                            state_q <= ST_HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The original request stays on the bus; a newer
                    // redirect replaces the pending target.
                    if (IMEM_RDY) begin
                        pc_q    <= redir ? redir_tgt : redir_pc_q;
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end else if (redir) begin
                        redir_pc_q <= redir_tgt;
                    end
                end
                ST_HOLD: begin
                    if (redir) begin
                        pc_q    <= redir_tgt;
                        state_q <= ST_IDLE;
                    end else if (!stall) begin
                        pc_q    <= pc_inc;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = pc_q;
    assign DE_V      = de_v_q;
    assign DE_IR     = de_ir_q;
    assign DE_NPC    = de_npc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, branch stall,
// redirect coincident with response, drain, priority/alignment, reset.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        IMEM_RDY;
    logic [31:0] IMEM_DATA;
    logic        BR_STALL;
    logic        V_MEM_STALL;
    logic        MEM_BR_TAKEN;
    logic [63:0] MEM_BR_TARGET;
    logic        DE_CS;
    logic [63:0] DE_MTVEC;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V;

    logic tag_mode;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    // Memory model: constant NOP, or a word tagged with its own address.
    assign IMEM_DATA = tag_mode ? {IMEM_ADDR[19:0], 12'h013} : 32'h0000_0013;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_RDY      (IMEM_RDY),
        .IMEM_DATA     (IMEM_DATA),
        .BR_STALL      (BR_STALL),
        .V_MEM_STALL   (V_MEM_STALL),
        .MEM_BR_TAKEN  (MEM_BR_TAKEN),
        .MEM_BR_TARGET (MEM_BR_TARGET),
        .DE_CS         (DE_CS),
        .DE_MTVEC      (DE_MTVEC),
        .DE_NPC        (DE_NPC),
        .DE_IR         (DE_IR),
        .DE_V          (DE_V)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {63'd0, IMEM_REQ}, 64'd0);
        check({tag, "_addr"}, IMEM_ADDR, 64'h0);
        check({tag, "_dev"}, {63'd0, DE_V}, 64'd0);
        check({tag, "_ir"}, {32'd0, DE_IR}, 64'd0);
        check({tag, "_npc"}, DE_NPC, 64'd0);
    endtask

    initial begin
        RESET_N       = 1'b0;
        IMEM_RDY      = 1'b1;
        BR_STALL      = 1'b0;
        V_MEM_STALL   = 1'b0;
        MEM_BR_TAKEN  = 1'b0;
        MEM_BR_TARGET = '0;
        DE_CS         = 1'b0;
        DE_MTVEC      = '0;
        tag_mode      = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        RESET_N = 1'b1;

        // Streaming NOPs
        tick();
        check("str_req", {63'd0, IMEM_REQ}, 64'd1);
        check("str_addr0", IMEM_ADDR, 64'h0);
        tick();
        check("str_v4", {63'd0, DE_V}, 64'd1);
        check("str_npc4", DE_NPC, 64'd4);
        check("str_ir", {32'd0, DE_IR}, 64'h13);
        tick();
        check("str_npc8", DE_NPC, 64'd8);
        check("str_v8", {63'd0, DE_V}, 64'd1);
        tick();
        check("str_npc12", DE_NPC, 64'd12);
        check("str_v12", {63'd0, DE_V}, 64'd1);

        // Restart with address-tagged data for the stall test
        RESET_N  = 1'b0;
        tag_mode = 1'b1;
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        check("stl_npc4", DE_NPC, 64'd4);
        tick();
        check("stl_npc8", DE_NPC, 64'd8);
        check("stl_ir8", {32'd0, DE_IR}, 64'h4013);
        check("stl_addr8", IMEM_ADDR, 64'd8);
        V_MEM_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_hold_npc", DE_NPC, 64'd8);
            check("stl_hold_ir", {32'd0, DE_IR}, 64'h4013);
            check("stl_hold_v", {63'd0, DE_V}, 64'd1);
            check("stl_noreq", {63'd0, IMEM_REQ}, 64'd0);
        end
        V_MEM_STALL = 1'b0;
        tick();
        check("stl_rel_npc", DE_NPC, 64'd12);
        check("stl_rel_ir", {32'd0, DE_IR}, 64'h8013);
        check("stl_rel_v", {63'd0, DE_V}, 64'd1);
        tick();
        check("stl_bubble", {63'd0, DE_V}, 64'd0);
        check("stl_addr12", IMEM_ADDR, 64'd12);
        check("stl_req12", {63'd0, IMEM_REQ}, 64'd1);
        tick();
        check("stl_npc16", DE_NPC, 64'd16);
        check("stl_ir16", {32'd0, DE_IR}, 64'hC013);

        // Branch stall then taken branch to 0x100
        BR_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("br_noreq", {63'd0, IMEM_REQ}, 64'd0);
            check("br_dev0", {63'd0, DE_V}, 64'd0);
        end
        BR_STALL      = 1'b0;
        MEM_BR_TAKEN  = 1'b1;
        MEM_BR_TARGET = 64'h100;
        tick();
        check("br_squash", {63'd0, DE_V}, 64'd0);
        check("br_idle", {63'd0, IMEM_REQ}, 64'd0);
        MEM_BR_TAKEN = 1'b0;
        tick();
        check("br_addr", IMEM_ADDR, 64'h100);
        check("br_req", {63'd0, IMEM_REQ}, 64'd1);

        // Redirect coincident with response: data dropped
        MEM_BR_TAKEN  = 1'b1;
        MEM_BR_TARGET = 64'h40;
        tick();
        check("co_dev0", {63'd0, DE_V}, 64'd0);
        check("co_req0", {63'd0, IMEM_REQ}, 64'd0);
        check("co_pc", IMEM_ADDR, 64'h40);
        MEM_BR_TAKEN = 1'b0;
        IMEM_RDY     = 1'b0;
        tick();
        check("dr_req40", {63'd0, IMEM_REQ}, 64'd1);
        check("dr_addr40", IMEM_ADDR, 64'h40);

        // Drain: redirect to 0x200 while 0x40 is outstanding
        MEM_BR_TAKEN  = 1'b1;
        MEM_BR_TARGET = 64'h200;
        tick();
        check("dr_keep_req", {63'd0, IMEM_REQ}, 64'd1);
        check("dr_keep_addr", IMEM_ADDR, 64'h40);
        check("dr_dev0", {63'd0, DE_V}, 64'd0);
        MEM_BR_TAKEN = 1'b0;
        IMEM_RDY     = 1'b1;
        tick();
        check("dr_discard", {63'd0, DE_V}, 64'd0);
        check("dr_done_req", {63'd0, IMEM_REQ}, 64'd0);
        IMEM_RDY = 1'b0;
        tick();
        check("dr_new_addr", IMEM_ADDR, 64'h200);
        check("dr_new_req", {63'd0, IMEM_REQ}, 64'd1);

        // Priority: trap beats branch
        DE_CS         = 1'b1;
        DE_MTVEC      = 64'h800;
        MEM_BR_TAKEN  = 1'b1;
        MEM_BR_TARGET = 64'h300;
        IMEM_RDY      = 1'b1;
        tick();
        check("pri_pc", IMEM_ADDR, 64'h800);
        DE_CS        = 1'b0;
        MEM_BR_TAKEN = 1'b0;
        IMEM_RDY     = 1'b0;
        tick();
        check("pri_addr", IMEM_ADDR, 64'h800);
        check("pri_req", {63'd0, IMEM_REQ}, 64'd1);

        // Misaligned target 0x302 realigns to 0x300 (via drain)
        MEM_BR_TAKEN  = 1'b1;
        MEM_BR_TARGET = 64'h302;
        tick();
        check("al_hold_addr", IMEM_ADDR, 64'h800);
        MEM_BR_TAKEN = 1'b0;
        IMEM_RDY     = 1'b1;
        tick();
        IMEM_RDY = 1'b0;
        tick();
        check("al_addr", IMEM_ADDR, 64'h300);
        check("al_req", {63'd0, IMEM_REQ}, 64'd1);

        // Reset asserted in the middle of a drain
        MEM_BR_TAKEN  = 1'b1;
        MEM_BR_TARGET = 64'h500;
        tick();
        check("rd_drain_req", {63'd0, IMEM_REQ}, 64'd1);
        check("rd_drain_addr", IMEM_ADDR, 64'h300);
        MEM_BR_TAKEN = 1'b0;
        IMEM_RDY     = 1'b1;
        RESET_N      = 1'b0;
        #1;
        check_reset_outputs("rd_now");
        tick();
        check_reset_outputs("rd_hold");
        RESET_N  = 1'b1;
        IMEM_RDY = 1'b0;
        tick();
        check("rd_first_req", {63'd0, IMEM_REQ}, 64'd1);
        check("rd_first_addr", IMEM_ADDR, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded on reset.
REQ-002 SHALL have port CLK input 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port RESET_N input 1: reset is asynchronous and active-low.
REQ-004 SHALL have port IMEM_REQ output 1, instruction-memory request valid.
REQ-005 SHALL have port IMEM_ADDR output 64, request address, word-aligned.
REQ-006 SHALL have port IMEM_RDY input 1, response handshake; IMEM_DATA is valid the same cycle.
REQ-007 SHALL have port IMEM_DATA input 32, fetched instruction.
REQ-008 SHALL have port BR_STALL input 1, a branch is in DE/EXE/MEM, so no new fetch is issued.
REQ-009 SHALL have port V_MEM_STALL input 1, downstream stall; the DE latch holds.
REQ-010 SHALL have port MEM_BR_TAKEN input 1, resolved taken branch or jump (one-cycle pulse).
REQ-011 SHALL have port MEM_BR_TARGET input 64, redirect target qualified by MEM_BR_TAKEN.
REQ-012 SHALL have port DE_CS input 1, trap/ecall redirect (one-cycle pulse).
REQ-013 SHALL have port DE_MTVEC input 64, trap vector qualified by DE_CS.
REQ-014 SHALL have ports DE_NPC output 64, DE_IR output 32 and DE_V output 1, registered decode-stage latch.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DRAIN and HOLD.
REQ-016 SHALL drive IMEM_REQ=1 only in REQ or DRAIN, holding IMEM_ADDR stable until IMEM_RDY.
REQ-017 SHALL move IDLE->REQ when BR_STALL=0 and HOLD is empty, using IMEM_ADDR=PC.
REQ-018 SHALL, in REQ with IMEM_RDY and V_MEM_STALL=0 and BR_STALL=0, load DE_IR=IMEM_DATA, DE_NPC=PC+4 and DE_V=1, set PC=PC+4, and stay in REQ (back-to-back, one instruction per cycle).
REQ-019 SHALL, in REQ with IMEM_RDY and (V_MEM_STALL or BR_STALL), capture data and PC+4 in the one-entry skid buffer and move to HOLD.
REQ-020 SHALL, in HOLD, transfer the buffer to the DE latch when V_MEM_STALL=0 and BR_STALL=0, set PC=PC+4, and return to IDLE.
REQ-021 SHALL load DE_V=0 (bubble) on any cycle with V_MEM_STALL=0 and no instruction delivered; with V_MEM_STALL=1, the DE latch holds all fields.
REQ-022 SHALL apply redirect priority DE_CS > MEM_BR_TAKEN > sequential; the new PC is {target[63:2],2'b00}.
REQ-023 SHALL, on redirect in IDLE or HOLD, load PC, discard the buffer, and go to IDLE.
REQ-024 SHALL, on redirect in REQ without IMEM_RDY, save the target in REDIR_PC and move to DRAIN.
REQ-025 SHALL, in DRAIN, keep the original request until IMEM_RDY, discard the data, load PC=REDIR_PC, and go to IDLE; a later redirect overwrites REDIR_PC.
REQ-026 SHALL, on redirect coincident with IMEM_RDY in REQ, discard the data, load the target, and go to IDLE.
REQ-027 SHALL, on any redirect cycle with V_MEM_STALL=0, load DE_V=0 (squash).
REQ-028 SHALL compute PC arithmetic modulo 2^64 (wraps at all-ones).

Reset
REQ-029 SHALL, on RESET_N=0 (asynchronous), force PC=RESET_PC, state IDLE, IMEM_REQ=0, DE_V=0, DE_IR=0, DE_NPC=0, buffer empty, REDIR_PC=0.
REQ-030 SHALL drop any outstanding request on reset mid-transaction and ignore IMEM_RDY while RESET_N=0; the first request issues in the first cycle after deassertion.

Structure
REQ-031 SHALL place FSM state encoding, the NOP/ILEN constant (4) and the redirect-cause encoding in the shared pipeline package.
REQ-032 SHALL implement the skid buffer as sub-module fetch_skid_buf (data 32, npc 64, valid).

Verification
REQ-033 SHALL verify streaming: RESET_PC=0, IMEM_RDY every cycle returning 0x00000013 -> DE_NPC 4, 8, 12 on consecutive cycles with DE_V=1.
REQ-034 SHALL verify stall: V_MEM_STALL=1 at PC=8 for 3 cycles with IMEM_RDY -> DE latch frozen, one buffered word, then DE_NPC=12 and no duplicate or lost instruction.
REQ-035 SHALL verify branch: BR_STALL high 3 cycles, then MEM_BR_TAKEN with target 0x100 -> no IMEM_REQ during the stall, next IMEM_ADDR=0x100, DE_V=0 during the stall.
REQ-036 SHALL verify drain: redirect to 0x200 while a request to 0x40 awaits IMEM_RDY (2-cycle latency) -> 0x40 data discarded, next IMEM_ADDR=0x200.
REQ-037 SHALL verify priority: DE_CS with DE_MTVEC 0x800 and MEM_BR_TAKEN with target 0x300 in the same cycle -> PC=0x800; target 0x302 -> IMEM_ADDR 0x300.
REQ-038 SHALL verify reset: RESET_N low mid-DRAIN -> all outputs at reset values immediately, first request to RESET_PC after release.
